// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: states, port ids and latched request bundle
// shared by the data-memory arbiter files.
package dmem_arb_pkg;

  localparam int ARB_AW = 64;
  localparam int ARB_DW = 64;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_ACCESS = 2'd1;
  localparam state_t S_RESP   = 2'd2;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_L = 1'b1;

  typedef struct packed {
    logic              we;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
    logic              port;
  } req_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: two-way winner select. Fixed priority (C first)
// by default, round-robin when DMEM_ARB_RR_EN is defined.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
  input  logic last_i,
`endif
  input  logic c_req_i,
  input  logic l_req_i,
  output logic win_c_o,
  output logic win_l_o
);

  logic c_first;

`ifdef DMEM_ARB_RR_EN
  assign c_first = (last_i == PORT_L);
`else
  assign c_first = 1'b1;
`endif

  assign win_c_o = c_req_i & (~l_req_i | c_first);
  assign win_l_o = l_req_i & ~win_c_o;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core (C)
// and loader/debug (L) ports. Macro DMEM_ARB_RR_EN selects round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_memwrite,
  output logic              m_memread,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              core_stall
);

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0] l_rdata_q, l_rdata_d;

  logic win_c, win_l;
  logic in_acc, in_resp, st_open, go, own_c;

  assign in_acc  = (state_q == S_ACCESS);
  assign in_resp = (state_q == S_RESP);
  assign st_open = (state_q == S_IDLE) | in_resp;
  assign go      = st_open & (win_c | win_l);
  assign own_c   = (req_q.port == PORT_C);

`ifdef DMEM_ARB_RR_EN
  logic last_q, last_d;

  assign last_d = go ? win_l : last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= PORT_L;
    else        last_q <= last_d;
  end

  dmem_arb_pick u_pick (
    .last_i  (last_q),
    .c_req_i (c_req),
    .l_req_i (l_req),
    .win_c_o (win_c),
    .win_l_o (win_l)
  );
`else
  dmem_arb_pick u_pick (
    .c_req_i (c_req),
    .l_req_i (l_req),
    .win_c_o (win_c),
    .win_l_o (win_l)
  );
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    c_rdata_d = c_rdata_q;
    l_rdata_d = l_rdata_q;
    unique case (1'b1)
      in_acc: begin
        state_d = req_q.we ? S_IDLE : S_RESP;
        if (!req_q.we && own_c)  c_rdata_d = m_rdata;
        if (!req_q.we && !own_c) l_rdata_d = m_rdata;
      end
      go: begin
        state_d     = S_ACCESS;
        req_d.port  = win_l;
        req_d.we    = win_l ? l_we : c_we;
        req_d.addr  = ARB_AW'(win_l ? l_addr : c_addr);
        req_d.wdata = ARB_DW'(win_l ? l_wdata : c_wdata);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      c_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      c_rdata_q <= c_rdata_d;
      l_rdata_q <= l_rdata_d;
    end
  end

  // Grants are combinational, so gate them while reset is held.
  assign c_gnt = reset & st_open & win_c;
  assign l_gnt = reset & st_open & win_l;

  assign c_rvalid = in_resp & own_c;
  assign l_rvalid = in_resp & ~own_c;
  assign c_rdata  = c_rdata_q;
  assign l_rdata  = l_rdata_q;

  assign m_addr     = in_acc ? ADDR_W'(req_q.addr) : '0;
  assign m_wdata    = in_acc ? DATA_W'(req_q.wdata) : '0;
  assign m_memwrite = in_acc & req_q.we;
  assign m_memread  = in_acc & ~req_q.we;

  assign core_stall = c_req & ~((c_gnt & c_we)
                              | (in_acc & own_c & req_q.we)
                              | c_rvalid);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a scoreboard of expected
// grant / memory / response events popped by a negedge monitor.
module tb_dmem_arbiter;

  localparam int K_GC  = 0;
  localparam int K_GL  = 1;
  localparam int K_MW  = 2;
  localparam int K_MR  = 3;
  localparam int K_RVC = 4;
  localparam int K_RVL = 5;

  localparam logic [63:0] M0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] M1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] DB = 64'h0000_0000_DEAD_BEEF;

  typedef struct {
    int          k;
    logic [63:0] a;
    logic [63:0] d;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, l_req, l_we;
  logic [63:0] c_addr, c_wdata, l_addr, l_wdata;
  logic        c_gnt, c_rvalid, l_gnt, l_rvalid;
  logic [63:0] c_rdata, l_rdata;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic        m_memwrite, m_memread, core_stall;

  logic [63:0] mem [0:31];
  ev_t         sb [$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .c_req      (c_req),
    .c_we       (c_we),
    .c_addr     (c_addr),
    .c_wdata    (c_wdata),
    .c_gnt      (c_gnt),
    .c_rvalid   (c_rvalid),
    .c_rdata    (c_rdata),
    .l_req      (l_req),
    .l_we       (l_we),
    .l_addr     (l_addr),
    .l_wdata    (l_wdata),
    .l_gnt      (l_gnt),
    .l_rvalid   (l_rvalid),
    .l_rdata    (l_rdata),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_memwrite (m_memwrite),
    .m_memread  (m_memread),
    .m_rdata    (m_rdata),
    .core_stall (core_stall)
  );

  always @(posedge clk) if (m_memwrite) mem[m_addr[7:3]] <= m_wdata;
  assign m_rdata = mem[m_addr[7:3]];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic push(int k, logic [63:0] a, logic [63:0] d);
    sb.push_back('{k, a, d});
  endtask

  task automatic pop_cmp(int k, logic [63:0] a, logic [63:0] d);
    ev_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL sb_unexpected act k=%0d a=%h d=%h exp none", k, a, d);
    end else begin
      e = sb.pop_front();
      if (e.k != k || e.a !== a || e.d !== d) begin
        bad++;
        $display("FAIL sb_event act k=%0d a=%h d=%h exp k=%0d a=%h d=%h",
                 k, a, d, e.k, e.a, e.d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (c_rvalid)   pop_cmp(K_RVC, 64'd0, c_rdata);
      if (l_rvalid)   pop_cmp(K_RVL, 64'd0, l_rdata);
      if (c_gnt)      pop_cmp(K_GC, c_addr, 64'd0);
      if (l_gnt)      pop_cmp(K_GL, l_addr, 64'd0);
      if (m_memwrite) pop_cmp(K_MW, m_addr, m_wdata);
      if (m_memread)  pop_cmp(K_MR, m_addr, 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic l_write(logic [63:0] a, logic [63:0] d);
    tick();
    l_req = 1'b1; l_we = 1'b1; l_addr = a; l_wdata = d;
    push(K_GL, a, 64'd0);
    push(K_MW, a, d);
    tick();
    l_req = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic wc;
    reset = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    c_req = 1'b1; l_req = 1'b1;
    #1;
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_l_gnt", l_gnt, 0);
    chk("rst_rvalid", {c_rvalid, l_rvalid}, 0);
    chk("rst_mem_ctl", {m_memwrite, m_memread}, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_rdata", c_rdata | l_rdata, 0);
    c_req = 1'b0; l_req = 1'b0;
    tick();
    reset = 1'b1;

    // core write alone
    tick();
    c_req = 1'b1; c_we = 1'b1; c_addr = 64'h10; c_wdata = DB;
    push(K_GC, 64'h10, 64'd0);
    push(K_MW, 64'h10, DB);
    #1;
    chk("wr_gnt_n", c_gnt, 1);
    chk("wr_stall_n", core_stall, 0);
    tick();
    c_req = 1'b0;
    #1;
    chk("wr_mw_n1", m_memwrite, 1);
    chk("wr_addr_n1", m_addr, 64'h10);
    chk("wr_data_n1", m_wdata, DB);
    tick();
    #1;
    chk("wr_mw_n2", m_memwrite, 0);
    chk("wr_stall_n2", core_stall, 0);

    // core read back
    tick();
    c_req = 1'b1; c_we = 1'b0; c_addr = 64'h10;
    push(K_GC, 64'h10, 64'd0);
    push(K_MR, 64'h10, 64'd0);
    push(K_RVC, 64'd0, DB);
    #1;
    chk("rd_gnt_n", c_gnt, 1);
    chk("rd_stall_n", core_stall, 1);
    tick();
    c_req = 1'b0;
    #1;
    chk("rd_mr_n1", m_memread, 1);
    tick();
    #1;
    chk("rd_rvalid_n2", c_rvalid, 1);
    chk("rd_rdata_n2", c_rdata, DB);
    chk("rd_l_rvalid_n2", l_rvalid, 0);

    l_write(64'h0, M0);
    l_write(64'h8, M1);

    // back-to-back L reads
    tick();
    l_req = 1'b1; l_we = 1'b0; l_addr = 64'h0;
    push(K_GL, 64'h0, 64'd0);
    push(K_MR, 64'h0, 64'd0);
    push(K_RVL, 64'd0, M0);
    push(K_GL, 64'h8, 64'd0);
    push(K_MR, 64'h8, 64'd0);
    push(K_RVL, 64'd0, M1);
    #1;
    chk("b2b_gnt_n", l_gnt, 1);
    tick();
    l_addr = 64'h8;
    #1;
    chk("b2b_gnt_n1", l_gnt, 0);
    tick();
    #1;
    chk("b2b_gnt_n2", l_gnt, 1);
    chk("b2b_rv_n2", l_rvalid, 1);
    chk("b2b_data_n2", l_rdata, M0);
    tick();
    l_req = 1'b0;
    tick();
    #1;
    chk("b2b_rv_n4", l_rvalid, 1);
    chk("b2b_data_n4", l_rdata, M1);
    tick();

    // simultaneous reads from reset
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      c_req = 1'b1; c_we = 1'b0; c_addr = 64'h0;
      l_req = 1'b1; l_we = 1'b0; l_addr = 64'h8;
`ifdef DMEM_ARB_RR_EN
      wc = (i % 2 == 0);
`else
      wc = 1'b1;
`endif
      push(wc ? K_GC : K_GL, wc ? 64'h0 : 64'h8, 64'd0);
      push(K_MR, wc ? 64'h0 : 64'h8, 64'd0);
      push(wc ? K_RVC : K_RVL, 64'd0, wc ? M0 : M1);
      #1;
      chk("tie_c_gnt", c_gnt, wc);
      chk("tie_l_gnt", l_gnt, !wc);
      tick();
      c_req = 1'b0; l_req = 1'b0;
      tick();
      #1;
      chk("tie_c_rv", c_rvalid, wc);
      chk("tie_l_rv", l_rvalid, !wc);
      tick();
    end

    // reset during ACCESS of an L write
    tick();
    l_req = 1'b1; l_we = 1'b1; l_addr = 64'h18; l_wdata = 64'h5555;
    push(K_GL, 64'h18, 64'd0);
    #1;
    chk("rw_gnt", l_gnt, 1);
    tick();
    #1;
    chk("rw_mw_pre", m_memwrite, 1);
    reset = 1'b0;
    #1;
    chk("rw_mw_rst", m_memwrite, 0);
    chk("rw_lgnt_rst", l_gnt, 0);
    chk("rw_lrv_rst", l_rvalid, 0);
    chk("rw_addr_rst", m_addr, 0);
    tick();
    reset = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 64'h10;
    l_we = 1'b0; l_addr = 64'h0;
    push(K_GC, 64'h10, 64'd0);
    push(K_MR, 64'h10, 64'd0);
    push(K_RVC, 64'd0, DB);
    #1;
    chk("post_c_gnt", c_gnt, 1);
    chk("post_l_gnt", l_gnt, 0);
    tick();
    c_req = 1'b0; l_req = 1'b0;
    tick();
    #1;
    chk("post_c_rv", c_rvalid, 1);
    chk("post_c_data", c_rdata, DB);
    tick();

    // idle bus
    repeat (10) begin
      tick();
      #1;
      chk("idle_ctl", {m_memwrite, m_memread}, 0);
      chk("idle_addr", m_addr, 0);
      chk("idle_wdata", m_wdata, 0);
      chk("idle_stall", core_stall, 0);
    end

    tick();
    chk("sb_drained", 64'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
